mem_stage_ctrl: RTL
===================

// Module: mem_stage_ctrl
// PURPOSE
//  MEM-stage consumer of EX/MEM pipeline outputs: issues data-memory bus transactions (req/ack, variable wait
//  states), stalls upstream stages while a load/store is outstanding, and loads MEM/WB result registers.
//  Sits between EX/MEM register and writeback; mem_stall feeds hazard unit (freezes PC, IF/ID, ID/EX, EX/MEM).
// PARAMETERS
//  TIMEOUT_CYCLES  16  ACCESS cycles without bus_ack before access aborted with bus_err (min 2)
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-low
//  ex_mem_wr      in   1   store from EX/MEM
//  ex_mem_rd      in   1   load from EX/MEM
//  ex_reg_wr      in   1   writeback enable
//  ex_mem_to_reg  in   2   writeback select
//  ex_reg_dst     in   5   destination register
//  ex_alu_result  in   32  address / ALU result
//  ex_write_data  in   32  store data (rt)
//  ex_next_pc     in   32  PC+4 for link writeback
//  bus_rdata      in   32  memory read data, valid with bus_ack
//  bus_ack        in   1   memory access complete (1-cycle pulse)
//  bus_req        out  1   registered; held high for whole access
//  bus_we         out  1   registered; 1 = write
//  bus_addr       out  32  registered word address
//  bus_wdata      out  32  registered store data
//  mem_stall      out  1   combinational; freeze upstream this cycle
//  bus_err        out  1   registered 1-cycle pulse on timeout
//  align_err      out  1   registered 1-cycle pulse on misaligned access (see CONFIGURATION)
//  wb_valid, wb_reg_wr out 1 each; wb_mem_to_reg out 2; wb_reg_dst out 5
//  wb_alu_result, wb_read_data, wb_next_pc  out 32 each  MEM/WB registers
// BEHAVIOUR
//  - Reset (async): every registered output 0, state IDLE, timeout counter 0; bus_req drops immediately,
//    including mid-access; a late bus_ack after reset release is ignored in IDLE.
//  - States IDLE, ACCESS, DONE. mem_stall = (IDLE & (ex_mem_rd|ex_mem_wr)) | ACCESS; 0 in DONE.
//  - IDLE, no memory op: at edge load WB regs from ex_* (wb_read_data<=0), wb_valid<=1; stay IDLE. 1-cycle latency.
//  - IDLE, memory op: latch bus_addr/bus_wdata/bus_we and ex_* control into holding regs; bus_req<=1;
//    wb_valid<=0 (bubble); ->ACCESS. ex_mem_rd & ex_mem_wr both 1: read performed, write suppressed (bus_we=0).
//  - ACCESS: counter +1 per cycle; wb_valid<=0. bus_ack: capture bus_rdata, bus_req<=0, ->DONE.
//    counter==TIMEOUT_CYCLES-1 with no ack: bus_err<=1, captured data<=0, bus_req<=0, ->DONE.
//    ack on the timeout cycle counts as success (no bus_err).
//  - DONE: WB regs load from holding regs + captured data, wb_valid<=1; counter<=0; ->IDLE. Inputs not sampled
//    (EX/MEM still shows same instr); next instr evaluated in following IDLE cycle.
//  - Store: wb_read_data=0, wb_reg_wr passes ex_reg_wr unchanged.
//  - Latency: load/store with ack after N ACCESS cycles (N>=1) = N+2 cycles stalled-to-retire; min 3.
//  - bus_ack outside ACCESS ignored. bus_addr/bus_wdata/bus_we stable while bus_req=1.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: IDLE memory op with ex_alu_result[1:0]!=0 -> no bus access, no stall;
//   retires in 1 cycle like non-memory op with wb_reg_wr<=0, wb_read_data<=0, align_err<=1 for 1 cycle.
//  Not defined: align_err tied 0; address passed unmodified (bus_addr[1:0] = ex_alu_result[1:0]).
// TESTING
//  1 ALU op ex_alu_result=0x1234, reg_dst=5, reg_wr=1 -> next cycle wb_valid=1, wb_alu_result=0x1234, stall never 1.
//  2 Load addr 0x100, ack 3 cycles after bus_req rises, rdata 0xDEADBEEF -> stall 4 cycles, bus_req 3 cycles,
//    wb_read_data=0xDEADBEEF, wb_valid=1 exactly once.
//  3 Store addr 0x200 data 0xCAFEF00D, ack first ACCESS cycle -> bus_we=1, bus_wdata=0xCAFEF00D, 3-cycle latency.
//  4 Load with no ack -> bus_req high TIMEOUT_CYCLES(16) cycles, bus_err 1 pulse, wb_read_data=0, return IDLE.
//  5 reset low during ACCESS -> bus_req, wb_valid, mem_stall 0 same cycle; ack after release ignored.
//  6 MEM_ALIGN_CHECK_EN: load addr 0x102 -> no bus_req, align_err pulse, wb_reg_wr=0; undefined: normal access 0x102.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer between the EX/MEM register and writeback.
// Issues one req/ack data-bus transaction per load/store, stalls upstream while it
// is in flight, aborts on a bus timeout, and loads the MEM/WB result registers.
// Optional build macro: MEM_ALIGN_CHECK_EN. When it is defined, a misaligned load
// or store retires at once without a bus access and pulses align_err.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_mem_wr,
  input  logic        ex_mem_rd,
  input  logic        ex_reg_wr,
  input  logic [1:0]  ex_mem_to_reg,
  input  logic [4:0]  ex_reg_dst,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_write_data,
  input  logic [31:0] ex_next_pc,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        mem_stall,
  output logic        bus_err,
  output logic        align_err,
  output logic        wb_valid,
  output logic        wb_reg_wr,
  output logic [1:0]  wb_mem_to_reg,
  output logic [4:0]  wb_reg_dst,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_next_pc
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Writeback control carried across the access while EX/MEM is frozen
  typedef struct packed {
    logic        reg_wr;
    logic [1:0]  mem_to_reg;
    logic [4:0]  reg_dst;
    logic [31:0] alu_result;
    logic [31:0] next_pc;
  } wb_ctl_t;

  state_t        state, state_nxt;
  wb_ctl_t       ex_ctl, hold;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic          mem_op, misalign, start, tmo;

  assign ex_ctl = {ex_reg_wr, ex_mem_to_reg, ex_reg_dst, ex_alu_result, ex_next_pc};
  assign mem_op = ex_mem_rd | ex_mem_wr;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = |ex_alu_result[1:0];
`else
  assign misalign = 1'b0;
`endif

  // A misaligned op (checking enabled) retires like an ALU op instead of going to the bus
  assign start = mem_op & ~misalign;
  assign tmo   = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and the combinational stall; stall is held off while in reset
  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        mem_stall = start;
        if (start) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_stall = 1'b1;
        if (bus_ack || tmo) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!reset) mem_stall = 1'b0;
  end

  // Bus request, holding registers, timeout counter and MEM/WB registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_err       <= 1'b0;
      align_err     <= 1'b0;
      cnt           <= '0;
      hold          <= '0;
      rdata_q       <= '0;
      wb_valid      <= 1'b0;
      wb_reg_wr     <= 1'b0;
      wb_mem_to_reg <= '0;
      wb_reg_dst    <= '0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_next_pc    <= '0;
    end else begin
      bus_err   <= 1'b0;
      align_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            // Read wins when both are set: the write is suppressed
            bus_req   <= 1'b1;
            bus_we    <= ex_mem_wr & ~ex_mem_rd;
            bus_addr  <= ex_alu_result;
            bus_wdata <= ex_write_data;
            hold      <= ex_ctl;
            wb_valid  <= 1'b0;
          end else begin
            wb_valid      <= 1'b1;
            wb_reg_wr     <= ex_reg_wr & ~(mem_op & misalign);
            wb_mem_to_reg <= ex_mem_to_reg;
            wb_reg_dst    <= ex_reg_dst;
            wb_alu_result <= ex_alu_result;
            wb_read_data  <= '0;
            wb_next_pc    <= ex_next_pc;
            align_err     <= mem_op & misalign;
          end
        end
        ACCESS: begin
          cnt      <= cnt + 1'b1;
          wb_valid <= 1'b0;
          if (bus_ack) begin
            // An ack on the timeout cycle still counts as success
            rdata_q <= bus_we ? '0 : bus_rdata;
            bus_req <= 1'b0;
          end else if (tmo) begin
            rdata_q <= '0;
            bus_err <= 1'b1;
            bus_req <= 1'b0;
          end
        end
        DONE: begin
          cnt           <= '0;
          wb_valid      <= 1'b1;
          wb_reg_wr     <= hold.reg_wr;
          wb_mem_to_reg <= hold.mem_to_reg;
          wb_reg_dst    <= hold.reg_dst;
          wb_alu_result <= hold.alu_result;
          wb_read_data  <= rdata_q;
          wb_next_pc    <= hold.next_pc;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
